// File: rtl/div_unit_pkg.sv
// div_unit_pkg: op encoding and FSM states for the iterative divider.
package div_unit_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS_A,
        S_ABS_B,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

endpackage

// File: rtl/constants.sv
// constants: project-wide width defaults shared by the execution units.
`ifndef XLEN
`define XLEN 32
`endif

// File: rtl/div_unit_adder.sv
// Adder: N-bit add/subtract with carry-out and condition flags; control=1 subtracts.
module Adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         control_i,
    output logic [N-1:0] sum_o,
    output logic         c_o,
    output logic         z_o,
    output logic         n_o,
    output logic         v_o
);
    logic [N-1:0] bx;
    assign bx = control_i ? ~b_i : b_i;
    assign {c_o, sum_o} = {1'b0, a_i} + {1'b0, bx} + {{N{1'b0}}, control_i};
    assign z_o = sum_o == '0;
    assign n_o = sum_o[N-1];
    assign v_o = (a_i[N-1] == bx[N-1]) && (sum_o[N-1] != a_i[N-1]);
endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider for DIV/DIVU/REM/REMU on one shared adder.
`ifndef XLEN
`define XLEN 32
`endif
module div_unit
    import div_unit_pkg::*;
#(
    parameter int N = `XLEN
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result
);
    localparam int CW = $clog2(N);
    localparam logic [N-1:0] MIN_INT = {1'b1, {(N-1){1'b0}}};

    state_e        state_q;
    op_e           op_q;
    logic [N-1:0]  quo_q, rem_q, b_q, result_q;
    logic [CW-1:0] cnt_q;
    logic          sa_q, sb_q;

    logic [N-1:0]  shifted, fix_val, add_a, add_b, sum;
    logic          fix_neg, carry;
    logic [2:0]    flags_unused;

    assign shifted = {rem_q[N-2:0], quo_q[N-1]};
    assign fix_val = op_q[1] ? rem_q : quo_q;
    // sa_q/sb_q already fold in "signed op", so only the sign rule differs by op
    assign fix_neg = op_q[1] ? sa_q : sa_q ^ sb_q;
    assign add_a   = (state_q == S_CALC) ? shifted : '0;
    assign add_b   = (state_q == S_ABS_A) ? quo_q : (state_q == S_FIX) ? fix_val : b_q;

    Adder #(.N(N)) u_adder (
        .a_i      (add_a),
        .b_i      (add_b),
        .control_i(1'b1),
        .sum_o    (sum),
        .c_o      (carry),
        .z_o      (flags_unused[0]),
        .n_o      (flags_unused[1]),
        .v_o      (flags_unused[2])
    );

    assign in_ready  = state_q == S_IDLE;
    assign out_valid = state_q == S_DONE;
    assign result    = result_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_DIV;
            quo_q    <= '0;
            rem_q    <= '0;
            b_q      <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
        end else if (flush) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    op_q  <= op_e'(op);
                    quo_q <= dividend;
                    rem_q <= '0;
                    b_q   <= divisor;
                    cnt_q <= '0;
                    sa_q  <= ~op[0] & dividend[N-1];
                    sb_q  <= ~op[0] & divisor[N-1];
                    if (divisor == '0) begin
                        result_q <= op[1] ? dividend : '1;
                        state_q  <= S_DONE;
                    end else if (~op[0] && dividend == MIN_INT && &divisor) begin
                        result_q <= op[1] ? '0 : dividend;
                        state_q  <= S_DONE;
                    end else begin
                        state_q <= S_ABS_A;
                    end
                end
                S_ABS_A: begin
                    quo_q   <= sa_q ? sum : quo_q;
                    state_q <= S_ABS_B;
                end
                S_ABS_B: begin
                    b_q     <= sb_q ? sum : b_q;
                    state_q <= S_CALC;
                end
                S_CALC: begin
                    rem_q   <= (carry | rem_q[N-1]) ? sum : shifted;
                    quo_q   <= {quo_q[N-2:0], carry | rem_q[N-1]};
                    cnt_q   <= cnt_q + 1'b1;
                    state_q <= (cnt_q == CW'(N - 1)) ? S_FIX : S_CALC;
                end
                S_FIX: begin
                    result_q <= fix_neg ? sum : fix_val;
                    state_q  <= S_DONE;
                end
                S_DONE: state_q <= out_ready ? S_IDLE : S_DONE;
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed checks of div_unit results, latency, handshake, flush and reset.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    int          errors = 0;
    int          checks = 0;
    int          cyc;

    always #5 clk = ~clk;

    div_unit #(.N(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .dividend(dividend), .divisor(divisor), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        chk("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1; op = o; dividend = a; divisor = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_done(input string tag, input logic [31:0] exp, input int lat);
        while (!out_valid && cyc < 60) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_latency"}, cyc, lat);
        chk({tag, "_result"}, result, exp);
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({tag, "_idle_after"}, {30'b0, in_ready, out_valid}, 32'b10);
    endtask

    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
        start_op(o, a, b);
        wait_done(tag, exp, lat);
        consume(tag);
    endtask

    initial begin
        #2;
        chk("reset_state", {result[29:0], in_ready, out_valid}, 32'b10);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("divu_100_7",  2'b01, 32'd100, 32'd7, 32'd14, 36);
        do_op("remu_100_7",  2'b11, 32'd100, 32'd7, 32'd2, 36);
        do_op("div_m7_2",    2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 36);
        do_op("rem_m7_2",    2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 36);
        do_op("rem_7_m2",    2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 36);
        do_op("div_100_m7",  2'b00, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 36);
        do_op("div_min_1",   2'b00, 32'h8000_0000, 32'd1, 32'h8000_0000, 36);
        do_op("remu_big",    2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 36);
        do_op("divu_min_m1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 36);
        do_op("divu_5_0",    2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        do_op("rem_5_0",     2'b10, 32'd5, 32'd0, 32'd5, 1);
        do_op("div_ovf",     2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("rem_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // result must hold while the consumer stalls
        start_op(2'b01, 32'd1000, 32'd10);
        wait_done("hold", 32'd100, 36);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 chk("hold_stable", {result[29:0], in_ready, out_valid},
                   {30'd100, 1'b0, 1'b1});
        end
        consume("hold");

        // flush at CALC iteration 5 (eighth edge after accept)
        start_op(2'b01, 32'd12345, 32'd3);
        repeat (7) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_idle", {30'b0, in_ready, out_valid}, 32'b10);
        repeat (40) begin
            @(posedge clk);
            #1 chk("flush_no_valid", {31'b0, out_valid}, 32'd0);
        end
        do_op("after_flush", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 36);

        // flush in IDLE beats in_valid
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; op = 2'b01; dividend = 32'd9; divisor = 32'd3;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        chk("flush_blocks_accept", {30'b0, in_ready, out_valid}, 32'b10);

        // asynchronous reset mid-CALC
        start_op(2'b01, 32'd500, 32'd7);
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("async_reset", {30'b0, in_ready, out_valid}, 32'b10);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("after_reset", 2'b11, 32'd500, 32'd7, 32'd3, 36);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
